// File: rtl/fir_mc_filter.sv
// Multi-channel time-multiplexed direct-form FIR: one MAC per clock over a shared, runtime-loadable
// coefficient set, with an arithmetic-shift scaler and saturation to the sample width.
module fir_mc_filter #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int ORDER    = 8,
  parameter int CHANNELS = 2,
  parameter int SHIFT    = 15,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int AD_W     = $clog2(ORDER + 1),
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(ORDER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_chan,
  input  logic              coef_we,
  input  logic [AD_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int K_W    = $clog2(ORDER + 2);
  localparam int NCOEF  = 2 ** AD_W;
  localparam int NHIST  = 2 ** AD_W;
  localparam int NCHAN  = 2 ** CH_W;
  localparam logic [K_W-1:0]  K_DONE   = K_W'(ORDER + 1);
  localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [AD_W:0]   AD_LIMIT = (AD_W + 1)'(ORDER);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e                   state_q, state_d;
  logic signed [COEF_W-1:0] coef_q [NCOEF];
  logic signed [DATA_W-1:0] hist_q [NCHAN][NHIST];
  logic signed [ACC_W-1:0]  acc_q, acc_d, accBase, shifted;
  logic signed [DATA_W-1:0] x_q, satData;
  logic [CH_W-1:0]          ch_q, outChan_q;
  logic [DATA_W-1:0]        outData_q;
  logic [K_W-1:0]           k_q;
  logic                     coefErr_q;
  logic [AD_W-1:0]          kIdx, histIdx;
  logic signed [COEF_W-1:0] mulCoef;
  logic signed [DATA_W-1:0] mulData;
  logic signed [PROD_W-1:0] prod;
  logic                     chanOk, addrOk, accept, macDone;

  assign chanOk   = {1'b0, in_chan} < CH_LIMIT;
  assign addrOk   = {1'b0, coef_addr} <= AD_LIMIT;
  assign accept   = in_valid && (state_q == IDLE) && chanOk;
  assign macDone  = (k_q == K_DONE);
  assign kIdx     = k_q[AD_W-1:0];
  assign histIdx  = kIdx - 1'b1;
  assign out_data = outData_q;
  assign out_chan = outChan_q;
  assign coef_err = coefErr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (macDone) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == OUT);
  end

  // The last MAC cycle only scales and saturates, keeping the adder off the saturation path.
  always_comb begin
    mulCoef = coef_q[0];
    mulData = in_data;
    accBase = '0;
    if (state_q == MAC) begin
      mulCoef = coef_q[kIdx];
      mulData = hist_q[ch_q][histIdx];
      accBase = acc_q;
    end
    prod    = PROD_W'(mulCoef) * PROD_W'(mulData);
    acc_d   = accBase + ACC_W'(prod);
    shifted = acc_q >>> SHIFT;
    if (shifted > SAT_MAX)      satData = {1'b0, {(DATA_W - 1){1'b1}}};
    else if (shifted < SAT_MIN) satData = {1'b1, {(DATA_W - 1){1'b0}}};
    else                        satData = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      x_q       <= '0;
      ch_q      <= '0;
      k_q       <= '0;
      outData_q <= '0;
      outChan_q <= '0;
      coefErr_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
      for (int c = 0; c < NCHAN; c++)
        for (int j = 0; j < NHIST; j++) hist_q[c][j] <= '0;
    end else begin
      coefErr_q <= 1'b0;
      if (coef_we) begin
        if ((state_q == IDLE) && addrOk) coef_q[coef_addr] <= coef_data;
        else                             coefErr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q   <= in_data;
            ch_q  <= in_chan;
            acc_q <= acc_d;
            k_q   <= K_W'(1);
          end
        end
        MAC: begin
          if (macDone) begin
            outData_q       <= satData;
            outChan_q       <= ch_q;
            hist_q[ch_q][0] <= x_q;
            for (int j = ORDER - 1; j > 0; j--) hist_q[ch_q][j] <= hist_q[ch_q][j-1];
          end else begin
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mc_filter.sv
// Bench for fir_mc_filter: a behavioural FIR model with an output scoreboard, plus directed
// vectors with literal expectations on a SHIFT=0 instance and a SHIFT=15 / ORDER=4 instance.
module tb_fir_mc_filter;
  localparam int ORD = 3;
  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady, outValid, outReady, coefWe, coefErr;
  logic [15:0] inData, outData, coefData;
  logic [1:0]  inChan, outChan, coefAddr;
  logic        inValidS, inReadyS, outValidS, outReadyS, coefWeS, coefErrS;
  logic [15:0] inDataS, outDataS, coefDataS;
  logic [0:0]  inChanS, outChanS;
  logic [2:0]  coefAddrS;

  int tests = 0;
  int fails = 0;

  longint mCoef [ORD+1];
  longint mHist [NCH][ORD];
  longint expData [$];
  longint expChan [$];

  always #5 clk = ~clk;

  fir_mc_filter #(.DATA_W(16), .COEF_W(16), .ORDER(ORD), .CHANNELS(NCH), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_chan(inChan), .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_chan(outChan), .coef_we(coefWe), .coef_addr(coefAddr), .coef_data(coefData),
    .coef_err(coefErr));

  fir_mc_filter #(.DATA_W(16), .COEF_W(16), .ORDER(4), .CHANNELS(2), .SHIFT(15)) dutS (
    .clk(clk), .reset(reset), .in_valid(inValidS), .in_ready(inReadyS), .in_data(inDataS),
    .in_chan(inChanS), .out_valid(outValidS), .out_ready(outReadyS), .out_data(outDataS),
    .out_chan(outChanS), .coef_we(coefWeS), .coef_addr(coefAddrS), .coef_data(coefDataS),
    .coef_err(coefErrS));

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k <= ORD; k++) mCoef[k] = 0;
    for (int c = 0; c < NCH; c++)
      for (int j = 0; j < ORD; j++) mHist[c][j] = 0;
    expData.delete();
    expChan.delete();
  endtask

  task automatic modelAccept(input longint x, input int ch);
    longint acc;
    acc = mCoef[0] * x;
    for (int k = 1; k <= ORD; k++) acc += mCoef[k] * mHist[ch][k-1];
    expData.push_back(sat16(acc));
    expChan.push_back(ch);
    for (int j = ORD - 1; j > 0; j--) mHist[ch][j] = mHist[ch][j-1];
    mHist[ch][0] = x;
  endtask

  always @(negedge clk) begin
    if (!reset && outValid) begin
      if (expData.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedOut: got data %0d chan %0d, expected no output",
                 $signed(outData), outChan);
      end else begin
        checkOutput("modelData", $signed(outData), expData[0]);
        checkOutput("modelChan", outChan, expChan[0]);
        if (outReady) begin
          void'(expData.pop_front());
          void'(expChan.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input longint x, input int ch, input bit doWe,
                               input int addr, input longint data);
    int n = 0;
    while (!inReady && n < 100) begin tick(); n++; end
    checkOutput("readyBeforeSend", inReady, 1);
    inValid = 1'b1; inData = x[15:0]; inChan = ch[1:0];
    coefWe = doWe; coefAddr = addr[1:0]; coefData = data[15:0];
    @(posedge clk);
    if (ch < NCH) modelAccept(x, ch);
    if (doWe) mCoef[addr] = data;
    #1;
    inValid = 1'b0;
    coefWe  = 1'b0;
  endtask

  task automatic sendAndExpect(input string tag, input longint x, input int ch, input longint expLit,
                               input bit doWe, input int addr, input longint data);
    int low = 0;
    int lat = 0;
    bit seen = 1'b0;
    applyStimulus(x, ch, doWe, addr, data);
    while (!inReady && low < 60) begin
      if (outValid && !seen) begin
        seen = 1'b1;
        lat  = low;
        checkOutput({tag, "Data"}, $signed(outData), expLit);
        checkOutput({tag, "Chan"}, outChan, ch);
      end
      tick();
      low++;
    end
    checkOutput({tag, "Seen"}, seen, 1);
    checkOutput({tag, "Latency"}, lat, ORD + 1);
    checkOutput({tag, "ReadyLow"}, low, ORD + 2);
  endtask

  task automatic waitOut(input string tag);
    int n = 0;
    while (!outValid && n < 50) begin tick(); n++; end
    checkOutput({tag, "Seen"}, outValid, 1);
  endtask

  task automatic writeCoef(input string tag, input int addr, input longint data, input bit expectOk);
    coefWe = 1'b1; coefAddr = addr[1:0]; coefData = data[15:0];
    @(posedge clk);
    if (expectOk) mCoef[addr] = data;
    #1;
    coefWe = 1'b0;
    checkOutput(tag, coefErr, expectOk ? 0 : 1);
  endtask

  task automatic setCoefs(input longint c0, input longint c1, input longint c2, input longint c3);
    writeCoef("coefW0", 0, c0, 1'b1);
    writeCoef("coefW1", 1, c1, 1'b1);
    writeCoef("coefW2", 2, c2, 1'b1);
    writeCoef("coefW3", 3, c3, 1'b1);
  endtask

  task automatic writeS(input string tag, input int addr, input longint data, input bit expectOk);
    coefWeS = 1'b1; coefAddrS = addr[2:0]; coefDataS = data[15:0];
    tick();
    coefWeS = 1'b0;
    checkOutput(tag, coefErrS, expectOk ? 0 : 1);
  endtask

  task automatic sendS(input string tag, input longint x, input longint expLit);
    int n = 0;
    while (!inReadyS && n < 50) begin tick(); n++; end
    inValidS = 1'b1; inDataS = x[15:0]; inChanS = 1'b0;
    tick();
    inValidS = 1'b0;
    n = 0;
    while (!outValidS && n < 50) begin tick(); n++; end
    checkOutput({tag, "Seen"}, outValidS, 1);
    checkOutput({tag, "Data"}, $signed(outDataS), expLit);
    tick();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    inValid = 1'b0; inData = '0; inChan = '0; outReady = 1'b1;
    coefWe = 1'b0; coefAddr = '0; coefData = '0;
    inValidS = 1'b0; inDataS = '0; inChanS = '0; outReadyS = 1'b1;
    coefWeS = 1'b0; coefAddrS = '0; coefDataS = '0;
    modelReset();
    #2;
    checkOutput("rstOutValid", outValid, 0);
    checkOutput("rstOutData", outData, 0);
    checkOutput("rstCoefErr", coefErr, 0);
    checkOutput("rstInReady", inReady, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 checkOutput("releaseInReady", inReady, 1);
    tick();

    setCoefs(1, 2, 3, 4);
    sendAndExpect("imp0", 1, 0, 1, 1'b0, 0, 0);
    sendAndExpect("imp1", 0, 0, 2, 1'b0, 0, 0);
    sendAndExpect("imp2", 0, 0, 3, 1'b0, 0, 0);
    sendAndExpect("imp3", 0, 0, 4, 1'b0, 0, 0);
    sendAndExpect("imp4", 0, 0, 0, 1'b0, 0, 0);

    setCoefs(1, 1, 1, 1);
    sendAndExpect("isoA0", 10, 0, 10, 1'b0, 0, 0);
    sendAndExpect("isoB0", 100, 1, 100, 1'b0, 0, 0);
    sendAndExpect("isoA1", 10, 0, 20, 1'b0, 0, 0);
    sendAndExpect("isoB1", 100, 1, 200, 1'b0, 0, 0);
    sendAndExpect("isoA2", 10, 0, 30, 1'b0, 0, 0);
    sendAndExpect("isoB2", 100, 1, 300, 1'b0, 0, 0);
    applyStimulus(999, 3, 1'b0, 0, 0);
    checkOutput("badChanIdle", inReady, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("badChanNoOut", outValid, 0);
    end
    sendAndExpect("isoA3", 10, 0, 40, 1'b0, 0, 0);

    setCoefs(32767, 32767, 0, 0);
    sendAndExpect("satP0", 32767, 2, 32767, 1'b0, 0, 0);
    sendAndExpect("satP1", 32767, 2, 32767, 1'b0, 0, 0);
    sendAndExpect("satN0", -32768, 2, -32767, 1'b0, 0, 0);
    sendAndExpect("satN1", -32768, 2, -32768, 1'b0, 0, 0);

    setCoefs(1, 2, 3, 4);
    outReady = 1'b0;
    applyStimulus(5, 0, 1'b0, 0, 0);
    waitOut("bp");
    checkOutput("bpData", $signed(outData), 95);
    inValid = 1'b1; inData = 16'd77; inChan = 2'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bpValid", outValid, 1);
      checkOutput("bpHold", $signed(outData), 95);
      checkOutput("bpInReady", inReady, 0);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    checkOutput("bpStillOut", inReady, 0);
    tick();
    checkOutput("bpReadyAfter", inReady, 1);

    applyStimulus(1, 1, 1'b0, 0, 0);
    writeCoef("macWriteErr", 1, 99, 1'b0);
    tick();
    checkOutput("macErrPulse", coefErr, 0);
    waitOut("macW");
    checkOutput("macWData", $signed(outData), 901);
    tick();
    sendAndExpect("c1Kept", 0, 1, 702, 1'b0, 0, 0);
    sendAndExpect("coinOld", 2, 0, 82, 1'b1, 0, 7);
    sendAndExpect("coinNew", 2, 0, 73, 1'b0, 0, 0);

    writeS("sC0", 0, 16384, 1'b1);
    sendS("shNeg", -3, -2);
    sendS("shPos", 3, 1);
    writeS("sAddr5", 5, 100, 1'b0);
    tick();
    checkOutput("sAddr5Clear", coefErrS, 0);

    applyStimulus(9, 0, 1'b0, 0, 0);
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstValid", outValid, 0);
    checkOutput("midRstData", outData, 0);
    checkOutput("midRstReady", inReady, 0);
    modelReset();
    @(posedge clk);
    #3 reset = 1'b0;
    #1 checkOutput("midRstRelease", inReady, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("midRstNoOut", outValid, 0);
    end
    sendAndExpect("zeroCoef", 5, 1, 0, 1'b0, 0, 0);
    setCoefs(1, 2, 3, 4);
    sendAndExpect("rstImp0", 1, 0, 1, 1'b0, 0, 0);
    sendAndExpect("rstImp1", 0, 0, 2, 1'b0, 0, 0);

    repeat (3) tick();
    checkOutput("queueDrained", expData.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
